// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
// Contents: requester count, index width, FSM state encoding.
package rr_arbiter16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  // state | meaning
  // IDLE  | no owner; grant the first requester found from ptr
  // GRANT | one owner holds the resource; watch its req and hold timer
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter16_pick.sv
// rr_pick16: combinational rotating priority finder.
// Ports:
//   req_masked  in  16  candidate request vector
//   start       in  4   highest-priority index for this search
//   found       out 1   any candidate present
//   idx         out 4   first set bit at or after start, wrapping mod 16
module rr_pick16
  import rr_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req_masked,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Walking the offsets from highest to lowest lets the nearest hit
  // overwrite farther ones; the index add wraps naturally in IDX_W bits,
  // which folds the rotate and un-rotate into one step.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (req_masked[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for 16 requesters with a per-owner
// hold limit.
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous active-high reset
//   req        in  16  request vector
//   gnt        out 16  registered one-hot grant (zero when no owner)
//   gnt_idx    out 4   index of current owner, valid with gnt_valid
//   gnt_valid  out 1   an owner exists
//   expired    out 1   one-cycle pulse after a timeout revocation
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             expired
);

  // Hold timer is a down-counter: loaded with MAX_HOLD-1 on each grant,
  // so reaching zero marks the cycle on which the owner has held
  // MAX_HOLD cycles. This fits in HOLD_W bits even for MAX_HOLD=2**HOLD_W.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             expired_q, expired_d;

  logic [IDX_W-1:0] pick_start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             timeout;
  logic             release_now;

  // In GRANT the search starts just past the owner, so the owner's own bit
  // is visited last: it only wins again when it is the sole requester,
  // which is exactly the lowest-priority re-entry a timed-out owner gets.
  // A voluntarily released owner has req low, so it can never win.
  assign pick_start = (state_q == GRANT) ? (idx_q + IDX_W'(1)) : ptr_q;

  rr_pick16 u_pick (
    .req_masked (req),
    .start      (pick_start),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign owner_req   = req[idx_q];
  assign timeout     = (hold_q == '0);
  assign release_now = ~owner_req | timeout;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    expired_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = GRANT;
        end else begin
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          ptr_d     = idx_q + IDX_W'(1);
          expired_d = timeout & owner_req;
          if (pick_found) begin
            idx_d  = pick_idx;
            hold_d = HOLD_LOAD;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    gnt_d = valid_d ? (N_REQ'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign expired   = expired_q;

endmodule
